snake_dir_ctrl: RTL and testbench
=================================

# snake_dir_ctrl

Direction controller for the snake's heading. It sits between the four per-button input conditioners, each of which delivers a clean single-cycle press pulse, and the game-step logic. It arbitrates simultaneous presses and filters illegal turns. Accepted turns wait in a small queue, and exactly one turn is released per game tick, so fast button taps are neither lost nor applied within a single step.

## Interface
- DEPTH, 2: queue entries for pending turns; legal range 1–4.
- RESET_DIR, RIGHT: heading loaded at reset, as a dir_t value.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- press_up, press_right, press_down, press_left  in  1 each  single-cycle press pulses.
- tick  in  1  game-step strobe, one cycle wide.
- dir  out  2  current heading; reset value RESET_DIR.
- moving  out  1  high once the game has started; reset value 0.
- changed  out  1  one-cycle pulse when dir changes on a tick; reset value 0.
- dropped  out  1  one-cycle pulse when a press is discarded; reset value 0.
- q_count  out  3  number of queued turns; reset value 0.

## Operation
- Encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3. The opposite of d is d XOR 2.
- Arbitration: if several presses arrive in one cycle, priority is up > right > down > left. The winner becomes the candidate; each loser raises dropped.
- Reference direction ("last"):
  - queue tail when the queue is non-empty, otherwise dir;
  - always sampled before any pop in the same cycle.
- FSM state WAIT (entered on reset):
  - tick is ignored and moving=0;
  - the first candidate, of any direction, loads dir directly;
  - the FSM then goes to RUN and moving=1 on the next cycle;
  - the queue stays empty.
- FSM state RUN, candidate filtering:
  - a candidate equal to last is a duplicate and is silently ignored, with no dropped pulse;
  - a candidate equal to opposite(last) is rejected and raises dropped;
  - otherwise the candidate is enqueued.
- RUN, full queue: an enqueue into a full queue (q_count==DEPTH) with no simultaneous tick is discarded and raises dropped.
- RUN, on tick with the queue non-empty: dir takes the head, the head is popped, and changed pulses.
- RUN, on tick with the queue empty: dir is held and changed stays 0.
- Simultaneous tick and enqueue: the pop and push both happen, so a full queue accepts the push. The new entry is never applied on the same tick, even when the queue was empty.
- Reset has priority over every other input. Mid-game, it clears the queue, restores RESET_DIR, clears moving, and returns the FSM to WAIT.
- The FSM has exactly two states, WAIT and RUN. RUN is left only by reset.

## Timing
- All outputs are registered.
- dir, changed and q_count update on the clock edge that samples tick.
- dropped is asserted in the cycle after the offending press was sampled.
- Press-to-heading latency: one cycle for the first press in WAIT. In RUN, a turn takes effect on the first tick sampled at least one cycle after the press, plus one tick per entry already ahead of it in the queue.
- Throughput: at most one enqueue and one dequeue per cycle.

## Configuration
- SNAKE_REVERSE_BLOCK_EN defined: the 180° reversal filter above is active.
- SNAKE_REVERSE_BLOCK_EN undefined:
  - opposite turns are enqueued like any other turn;
  - only duplicate and full-queue rules apply;
  - dropped fires only for arbitration losers and full-queue discards.

## Structure
- Package snake_pkg holds:
  - typedef enum logic [1:0] dir_t {UP, RIGHT, DOWN, LEFT};
  - function opposite(dir_t);
  - the FSM state typedef {WAIT, RUN}.
- Sub-module dir_fifo implements the queue:
  - parameter DEPTH;
  - ports push, pop, din, head, tail, count, full, empty;
  - push and pop are legal together when full.
- snake_dir_ctrl contains the arbiter, the filter, the FSM and the output registers.

## Test plan
- Start from WAIT: after reset, dir=RIGHT and moving=0. press_left in WAIT gives dir=LEFT and moving=1 one cycle later, with changed=0. Any tick before the press has no effect.
- Queued turns: in RUN with dir=RIGHT, press_up then press_left on separate cycles gives q_count=2. The first tick gives dir=UP with a changed pulse; the second tick gives dir=LEFT.
- Reversal: in RUN with dir=RIGHT, press_left gives a dropped pulse and q_count=0. Without SNAKE_REVERSE_BLOCK_EN, the same press is enqueued and the next tick gives dir=LEFT.
- Arbitration and duplicates:
  - press_up and press_down in the same cycle, dir=RIGHT: UP is queued and dropped pulses once;
  - a following press_up is a duplicate, so q_count stays 1 and no dropped pulse.
- Full queue: with DEPTH=2 and the queue full, a press alone gives dropped. The same press arriving together with tick is accepted, and q_count stays 2.
- Reset mid-game: with moving=1, dir=UP and q_count=2, asserting reset gives dir=RIGHT, moving=0 and q_count=0 on the next cycle. A tick right after reset is ignored.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake heading controller: direction encoding,
// the reversal helper and the two-state controller FSM encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Reversing a heading flips bit 1 of the encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small shift-style queue of pending turns: entry 0 is always the head,
// the tail is the newest entry. Push and pop may coincide even when full.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  dir_t       din,
  output dir_t       head,
  output dir_t       tail,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  dir_t       r_mem [DEPTH];
  logic [2:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;
  logic [2:0] w_wr_idx;

  assign count = r_count;
  assign full  = (r_count == 3'(DEPTH));
  assign empty = (r_count == 3'd0);
  assign head  = r_mem[0];

  always_comb begin
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
    // A simultaneous pop shifts everything down, so the write slot moves too.
    w_wr_idx  = r_count - {2'b00, w_do_pop};
  end

  always_comb begin
    tail = r_mem[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (r_count == 3'(i + 1)) tail = r_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 3'd0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= UP;
    end else begin
      if (w_do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i + 1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_do_push && (w_wr_idx == 3'(i))) r_mem[i] <= din;
      end
      r_count <= r_count + {2'b00, w_do_push} - {2'b00, w_do_pop};
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: arbitrates presses, filters turns, queues them
// and releases one per tick. Define SNAKE_REVERSE_BLOCK_EN to reject 180° turns.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int   DEPTH     = 2,
  parameter dir_t RESET_DIR = RIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press_up,
  input  logic       press_right,
  input  logic       press_down,
  input  logic       press_left,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       moving,
  output logic       changed,
  output logic       dropped,
  output logic [2:0] q_count,
  output state_t     o_dbg_state
);

  state_t     r_state;
  dir_t       r_dir;
  logic       r_moving;
  logic       r_changed;
  logic       r_dropped;

  dir_t       w_cand;
  logic       w_cand_valid;
  logic       w_multi;
  dir_t       w_last;
  logic       w_dup;
  logic       w_rev;
  logic       w_run;
  logic       w_want;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;

  dir_t       w_head;
  dir_t       w_tail;
  logic [2:0] w_count;
  logic       w_full;
  logic       w_empty;

  // Fixed-priority arbiter: up > right > down > left.
  always_comb begin
    w_cand       = UP;
    w_cand_valid = 1'b1;
    if (press_up)         w_cand = UP;
    else if (press_right) w_cand = RIGHT;
    else if (press_down)  w_cand = DOWN;
    else if (press_left)  w_cand = LEFT;
    else                  w_cand_valid = 1'b0;
  end

  assign w_multi = (press_up    && (press_right || press_down || press_left)) ||
                   (press_right && (press_down || press_left)) ||
                   (press_down  && press_left);

  // Reference heading is taken before any pop in the same cycle.
  always_comb begin
    w_run  = (r_state == RUN);
    w_last = w_empty ? r_dir : w_tail;
    w_dup  = (w_cand == w_last);
`ifdef SNAKE_REVERSE_BLOCK_EN
    w_rev  = (w_cand == opposite(w_last));
`else
    w_rev  = 1'b0;
`endif
    w_pop  = w_run && tick && !w_empty;
    w_want = w_run && w_cand_valid && !w_dup && !w_rev;
    w_push = w_want && (!w_full || tick);
    w_drop = w_multi ||
             (w_run && w_cand_valid && w_rev) ||
             (w_want && w_full && !tick);
  end

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_cand),
    .head  (w_head),
    .tail  (w_tail),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= WAIT;
      r_dir     <= RESET_DIR;
      r_moving  <= 1'b0;
      r_changed <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_changed <= w_pop;
      r_dropped <= w_drop;
      case (r_state)
        WAIT: begin
          if (w_cand_valid) begin
            r_dir    <= w_cand;
            r_moving <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (w_pop) r_dir <= w_head;
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  assign dir         = r_dir;
  assign moving      = r_moving;
  assign changed     = r_changed;
  assign dropped     = r_dropped;
  assign q_count     = w_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios with literal expectations,
// then random presses/ticks/resets checked every cycle against a queue model.
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  localparam int DEPTH = 2;
`ifdef SNAKE_REVERSE_BLOCK_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       press_up = 1'b0, press_right = 1'b0, press_down = 1'b0, press_left = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic       moving, changed, dropped;
  logic [2:0] q_count;
  state_t     dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // model state
  int m_dir = 0;
  int m_moving = 0;
  int m_changed = 0;
  int m_dropped = 0;
  int m_q[$];

  snake_dir_ctrl #(.DEPTH(DEPTH), .RESET_DIR(RIGHT)) dut (
    .clk         (clk),
    .reset       (reset),
    .press_up    (press_up),
    .press_right (press_right),
    .press_down  (press_down),
    .press_left  (press_left),
    .tick        (tick),
    .dir         (dir),
    .moving      (moving),
    .changed     (changed),
    .dropped     (dropped),
    .q_count     (q_count),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit u, input bit r, input bit d, input bit l,
                     input bit t, input bit rs);
    @(negedge clk);
    press_up = u; press_right = r; press_down = d; press_left = l;
    tick = t; reset = rs;
    @(posedge clk);
    #1;
  endtask

  // Reference model: heading, started flag and a plain queue of turns.
  always @(posedge clk) begin
    int p[4];
    int n, cand, last;
    bit full_before;
    p = '{int'(press_up), int'(press_right), int'(press_down), int'(press_left)};
    n = 0; cand = -1;
    for (int i = 0; i < 4; i++) begin
      if (p[i] != 0) begin
        n++;
        if (cand < 0) cand = i;
      end
    end
    m_changed = 0;
    m_dropped = (n > 1) ? 1 : 0;
    if (reset) begin
      m_dir = 1; m_moving = 0; m_dropped = 0;
      m_q.delete();
    end else if (m_moving == 0) begin
      if (n > 0) begin
        m_dir = cand; m_moving = 1;
      end
    end else begin
      last = (m_q.size() > 0) ? m_q[$] : m_dir;
      full_before = (m_q.size() >= DEPTH);
      if (tick && m_q.size() > 0) begin
        m_dir = m_q.pop_front();
        m_changed = 1;
      end
      if (n > 0 && cand != last) begin
        if (REV && cand == (last ^ 2)) m_dropped = 1;
        else if (full_before && !tick) m_dropped = 1;
        else m_q.push_back(cand);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_dir", int'(dir), m_dir);
      chk("model_moving", int'(moving), m_moving);
      chk("model_changed", int'(changed), m_changed);
      chk("model_dropped", int'(dropped), m_dropped);
      chk("model_q_count", int'(q_count), m_q.size());
      chk("model_state", int'(dbg_state), m_moving);
    end
  end

  initial begin
    // Start from WAIT
    cyc(0,0,0,0,0,1);
    check_en = 1'b1;
    cyc(0,0,0,0,0,1);
    chk("rst_dir", int'(dir), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_q", int'(q_count), 0);
    cyc(0,0,0,0,1,0);
    chk("wait_tick_dir", int'(dir), 1);
    chk("wait_tick_moving", int'(moving), 0);
    cyc(0,0,0,1,0,0);
    chk("wait_left_dir", int'(dir), 3);
    chk("wait_left_moving", int'(moving), 1);
    chk("wait_left_changed", int'(changed), 0);

    // Queued turns
    cyc(0,0,0,0,0,1);
    cyc(0,1,0,0,0,0);
    cyc(1,0,0,0,0,0);
    cyc(0,0,0,1,0,0);
    chk("queue_two", int'(q_count), 2);
    cyc(0,0,0,0,1,0);
    chk("tick1_dir", int'(dir), 0);
    chk("tick1_changed", int'(changed), 1);
    cyc(0,0,0,0,1,0);
    chk("tick2_dir", int'(dir), 3);
    chk("tick2_q", int'(q_count), 0);

    // Reversal
    cyc(0,0,0,0,0,1);
    cyc(0,1,0,0,0,0);
    cyc(0,0,0,1,0,0);
    if (REV) begin
      chk("rev_dropped", int'(dropped), 1);
      chk("rev_q", int'(q_count), 0);
    end else begin
      chk("rev_q_open", int'(q_count), 1);
      cyc(0,0,0,0,1,0);
      chk("rev_dir_open", int'(dir), 3);
    end

    // Arbitration, duplicate, full queue
    cyc(0,0,0,0,0,1);
    cyc(0,1,0,0,0,0);
    cyc(1,0,1,0,0,0);
    chk("arb_q", int'(q_count), 1);
    chk("arb_dropped", int'(dropped), 1);
    cyc(1,0,0,0,0,0);
    chk("dup_q", int'(q_count), 1);
    chk("dup_dropped", int'(dropped), 0);
    cyc(0,0,0,1,0,0);
    chk("fill_q", int'(q_count), 2);
    cyc(0,0,1,0,0,0);
    chk("full_dropped", int'(dropped), 1);
    chk("full_q", int'(q_count), 2);
    cyc(0,0,1,0,1,0);
    chk("full_tick_dropped", int'(dropped), 0);
    chk("full_tick_q", int'(q_count), 2);
    chk("full_tick_dir", int'(dir), 0);

    // Reset mid-game
    cyc(0,0,0,0,0,1);
    chk("mid_rst_dir", int'(dir), 1);
    chk("mid_rst_moving", int'(moving), 0);
    chk("mid_rst_q", int'(q_count), 0);
    cyc(0,0,0,0,1,0);
    chk("post_rst_tick_dir", int'(dir), 1);
    chk("post_rst_tick_moving", int'(moving), 0);

    // Random phase
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0,5) == 0, $urandom_range(0,5) == 0,
          $urandom_range(0,5) == 0, $urandom_range(0,5) == 0,
          $urandom_range(0,3) == 0, $urandom_range(0,199) == 0);
    end
    cyc(0,0,0,0,0,0);
    @(posedge clk);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
